// File: rtl/mb_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : mb_tx                                                          |
// | Brief   : UCIe mainband transmitter - flit FIFO feeding a 16-lane        |
// |           serializer with 4-high/4-low valid framing. Optional lane      |
// |           reversal is enabled by defining MB_TX_LANE_REVERSAL_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mb_tx #(
  parameter int flit_buffer_size = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic [7:0]  data_i [63:0],
`ifdef MB_TX_LANE_REVERSAL_EN
  input  logic        lane_rev_i,
`endif
  output logic        ready_o,
  output logic [15:0] dataPins_o,
  output logic        valid_oPin,
  output logic        clk_fwd_en_o,
  output logic        busy_o
);

  localparam int         c_ADDR_W = $clog2(flit_buffer_size);
  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_SEND   = 1'b1;

  logic [511:0]      r_mem [flit_buffer_size];
  logic [511:0]      w_flit_in;
  logic [511:0]      r_shift;
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic [c_ADDR_W:0] w_wr_ptr_next;
  logic [c_ADDR_W:0] w_rd_ptr_next;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_full_next;
  logic              r_ready;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [1:0]        r_chunk;
  logic [2:0]        r_ui;
  logic              w_last;
  logic [15:0]       w_lane;
  logic [15:0]       w_pins_next;
  logic              w_valid_next;
  logic              w_fwd_next;
  logic              w_busy_next;
  logic [15:0]       r_pins;
  logic              r_valid;
  logic              r_fwd;
  logic              r_busy;

  // ---------------- flit FIFO ----------------
  always_comb begin
    w_flit_in = '0;
    for (int i = 0; i < 64; i++) begin
      w_flit_in[8*i +: 8] = data_i[i];
    end
  end

  assign w_push        = valid_i && r_ready;
  assign w_wr_ptr_next = r_wr_ptr + {{c_ADDR_W{1'b0}}, w_push};
  assign w_rd_ptr_next = r_rd_ptr + {{c_ADDR_W{1'b0}}, w_pop};
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                         (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign w_full_next   = (w_wr_ptr_next[c_ADDR_W] != w_rd_ptr_next[c_ADDR_W]) &&
                         (w_wr_ptr_next[c_ADDR_W-1:0] == w_rd_ptr_next[c_ADDR_W-1:0]);

  // Holding ready low while currently full delays the rise by one cycle after a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_ready  <= !(w_full || w_full_next);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_flit_in;
    end
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    end
  end

`ifdef MB_TX_LANE_REVERSAL_EN
  logic r_rev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rev <= 1'b0;
    end else if (w_pop) begin
      r_rev <= lane_rev_i;
    end
  end
`endif

  // ---------------- serializer: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
      r_chunk <= 2'd0;
      r_ui    <= 3'd0;
      r_pins  <= 16'h0000;
      r_valid <= 1'b0;
      r_fwd   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_chunk <= 2'd0;
        r_ui    <= 3'd0;
      end else if (r_state == c_SEND) begin
        {r_chunk, r_ui} <= {r_chunk, r_ui} + 5'd1;
      end
      r_pins  <= w_pins_next;
      r_valid <= w_valid_next;
      r_fwd   <= w_fwd_next;
      r_busy  <= w_busy_next;
    end
  end

  // ---------------- serializer: next state ----------------
  assign w_last = (r_chunk == 2'd3) && (r_ui == 3'd7);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = c_SEND;
        end
      end
      c_SEND: begin
        if (w_last) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = c_IDLE;
          end
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // ---------------- serializer: outputs ----------------
  // Bit index {chunk, lane, ui} equals (chunk*16 + lane)*8 + ui.
  always_comb begin
    w_lane = '0;
    for (int l = 0; l < 16; l++) begin
      w_lane[l] = r_shift[{r_chunk, l[3:0], r_ui}];
    end
    w_pins_next  = 16'h0000;
    w_valid_next = 1'b0;
    w_fwd_next   = 1'b0;
    if (r_state == c_SEND) begin
`ifdef MB_TX_LANE_REVERSAL_EN
      w_pins_next = r_rev ? {<<{w_lane}} : w_lane;
`else
      w_pins_next = w_lane;
`endif
      w_valid_next = ~r_ui[2];
      w_fwd_next   = 1'b1;
    end
    w_busy_next = (r_state == c_SEND) || (w_state_next == c_SEND) ||
                  (w_wr_ptr_next != w_rd_ptr_next);
  end

  assign ready_o      = r_ready;
  assign dataPins_o   = r_pins;
  assign valid_oPin   = r_valid;
  assign clk_fwd_en_o = r_fwd;
  assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: doc/mb_tx.md
# mb_tx

Mainband transmitter for the UCIe logical PHY; it is the transmit-side counterpart of `MB_RX`. It accepts whole 64-byte flits from the adapter side into a flit buffer and serializes each one across 16 data lanes, one bit per lane per UI. Alongside the data it drives the valid pin with the 4-high/4-low framing that the receiver expects. It sits between the adapter flit interface and the mainband pin drivers and runs on a single UI-rate clock, with one `clk` edge per UI.

## Interface
- `flit_buffer_size`, 4: flit FIFO depth in flits; must be a power of 2 and ≥ 2.
- `clk`  in  1: UI-rate clock; every output changes only on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `valid_i`  in  1: a flit is presented on `data_i`.
- `data_i`  in  8×64 (`[7:0] data_i [63:0]`): the flit; `data_i[0]` is transmitted first.
- `ready_o`  out  1: the FIFO can accept a flit; a flit is accepted when `valid_i && ready_o` at posedge.
- `dataPins_o`  out  16: mainband data lanes.
- `valid_oPin`  out  1: mainband valid lane.
- `clk_fwd_en_o`  out  1: request to forward the peripheral clock; high while transmitting.
- `busy_o`  out  1: the serializer holds a flit or the FIFO is non-empty.
- `lane_rev_i`  in  1: lane reversal select; present only with `MB_TX_LANE_REVERSAL_EN`.

## Operation
- **FIFO:** `flit_buffer_size` entries of 512 bits, with read and write pointers of width log2(depth)+1.
  - `ready_o` = !full, registered from pointer state only.
  - `ready_o` has no combinational path from the same-cycle pop.
- **Serializer states**
  - `IDLE`: pins are 0. If the FIFO is non-empty, pop the head into the shift register and go to `SEND` with `chunk` = 0 and `ui` = 0.
  - `SEND`: drive UI (`chunk`, `ui`). Increment `ui` (3 bits); when `ui` wraps 7→0, increment `chunk` (2 bits).
  - At (`chunk` = 3, `ui` = 7):
    - If the FIFO is non-empty, pop the next flit and stay in `SEND` with no gap.
    - Otherwise go to `IDLE`.
- **Per UI in `SEND`**
  - `dataPins_o[l]` = `flit[chunk*16 + l][ui]`, so bits go LSB first.
  - `valid_oPin` = (`ui` < 4).
  - `clk_fwd_en_o` = 1.
- **Flit length:** 4 chunks × 8 UI = 32 UI per flit.
- **Throughput:** 1 flit per 32 cycles sustained.
- **Simultaneous push and pop:** allowed in the same cycle when the FIFO is neither full nor empty. On the cycle a full FIFO is popped, `ready_o` stays 0 and rises on the next cycle.
- **`valid_i` while `ready_o` = 0:** the flit is ignored; the bench must hold it.

## Timing
- **Reset values:** `ready_o` = 1; `dataPins_o` = 16'h0000; `valid_oPin` = 0; `clk_fwd_en_o` = 0; `busy_o` = 0; FIFO empty; state `IDLE`.
- **Reset assertion mid-flit:**
  - Outputs clear asynchronously.
  - The partial flit and all buffered flits are discarded.
  - No resume after deassertion.
- **Latency:** a flit accepted at posedge T into an empty FIFO with the serializer in `IDLE` appears as UI0 on the pins after posedge T+2. The pins are registered.
- **Last UI:** after a flit's final UI (`chunk` 3, `ui` 7) with the FIFO empty, the pins return to 0 and `clk_fwd_en_o` to 0 on the next posedge.
- **`busy_o`:** falls on that same posedge.
- **Back-to-back flits:** UI0 of flit N+1 directly follows UI7 of chunk 3 of flit N.

## Configuration
- **`MB_TX_LANE_REVERSAL_EN` defined:**
  - Port `lane_rev_i` exists.
  - When it is 1, `dataPins_o[15-l]` = `flit[chunk*16 + l][ui]`.
  - It is sampled at flit load and held constant for the whole flit.
  - `valid_oPin` is unaffected.
- **Not defined:** the port is absent and the lane mapping is always identity.

## Test plan
- **Reset, then no stimulus:** `ready_o` = 1; all pins 0 for 100 cycles; `busy_o` = 0.
- **Single flit "Hello, World! Th…" accepted at T:**
  - At T+2, `dataPins_o` = 16'h1192 and `valid_oPin` = 1.
  - `valid_oPin` pattern is 1111_0000 repeated 4 times.
  - Pins are 0 at T+34.
- **Three flits pushed on consecutive cycles, depth 4:**
  - 96 contiguous UI with no gap.
  - Data decoded byte-for-byte equals the inputs.
  - `ready_o` never drops.
- **Depth 4, five flits offered back-to-back:**
  - `ready_o` falls after the 4th push if the serializer has not yet popped.
  - The 5th flit is accepted only after a pop.
  - Nothing is lost or duplicated.
- **`reset_n` pulsed low at UI 13 of a flit with 2 flits queued:**
  - Pins go to 0 immediately.
  - After release, `busy_o` = 0 and nothing is transmitted.
- **Lane reversal, with `MB_TX_LANE_REVERSAL_EN` defined and `lane_rev_i` = 1:**
  - The same "Hello" flit gives 16'h4988 at UI0.
  - With the macro undefined, the bench sees 16'h1192.
